// File: rtl/signmag_to_bcd_serial.sv
// Serial double-dabble converter: sign-magnitude in, packed BCD, display sign
// and leading-zero blanking mask out. One magnitude bit is consumed per clock.
//
// Ports:
//   Clock_in, Reset_in           clock, synchronous active-high reset
//   Start_in, Magnitude_in,      conversion request; the value and its sign
//   Is_negative_in               are sampled only at an accepted start
//   Busy_out, Done_out           busy level, one-cycle result-valid pulse
//   Bcd_out, Is_negative_out,    held result: digits (units in [3:0]),
//   Digit_enable_out             minus sign, per-digit display enable
module signmag_to_bcd_serial #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                Clock_in,
  input  logic                Reset_in,
  input  logic                Start_in,
  input  logic [WIDTH-1:0]    Magnitude_in,
  input  logic                Is_negative_in,
  output logic                Busy_out,
  output logic                Done_out,
  output logic [4*DIGITS-1:0] Bcd_out,
  output logic                Is_negative_out,
  output logic [DIGITS-1:0]   Digit_enable_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                busy;
  logic                last;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scr;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scr_nxt;
  logic [CW-1:0]       cnt;
  logic                sign;
  logic                seen;
  logic [DIGITS-1:0]   en_nxt;
  logic                done_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q;
  logic [DIGITS-1:0]   en_q;

  always_ff @(posedge Clock_in) begin
    if (Reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start_in) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // add-3 on digits >= 5, then shift the next magnitude bit in
  always_comb begin
    adj = scr;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr[4*i+:4] >= 4'd5) begin
        adj[4*i+:4] = scr[4*i+:4] + 4'd3;
      end
    end
    scr_nxt = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
  end

  // a digit shows if it or any more significant digit is nonzero
  always_comb begin
    seen   = 1'b0;
    en_nxt = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen      = seen | (scr_nxt[4*i+:4] != 4'd0);
      en_nxt[i] = seen;
    end
    en_nxt[0] = 1'b1;
  end

  always_ff @(posedge Clock_in) begin
    if (Reset_in) begin
      shreg  <= '0;
      scr    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      neg_q  <= 1'b0;
      en_q   <= DIGITS'(1);
    end else begin
      done_q <= last;
      if (state == IDLE && Start_in) begin
        shreg <= Magnitude_in;
        sign  <= Is_negative_in;
        scr   <= '0;
        cnt   <= '0;
      end else if (busy) begin
        scr   <= scr_nxt;
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt   <= cnt + 1'b1;
        if (last) begin
          bcd_q <= scr_nxt;
          neg_q <= sign & (|scr_nxt);
          en_q  <= en_nxt;
        end
      end
    end
  end

  assign Busy_out         = busy;
  assign Done_out         = done_q;
  assign Bcd_out          = bcd_q;
  assign Is_negative_out  = neg_q;
  assign Digit_enable_out = en_q;

endmodule

// File: tb/tb_signmag_to_bcd_serial.sv
// Directed bench for signmag_to_bcd_serial: hand-computed BCD results,
// latency, busy length, start-while-busy, mid-conversion reset, streaming.
module tb_signmag_to_bcd_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mag;
  logic        neg;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        neg_o;
  logic [4:0]  en;

  int errs   = 0;
  int checks = 0;
  int lat;
  int bcnt;
  int dcnt;

  always #5 clk = ~clk;

  signmag_to_bcd_serial dut (
    .Clock_in        (clk),
    .Reset_in        (rst),
    .Start_in        (start),
    .Magnitude_in    (mag),
    .Is_negative_in  (neg),
    .Busy_out        (busy),
    .Done_out        (done),
    .Bcd_out         (bcd),
    .Is_negative_out (neg_o),
    .Digit_enable_out(en)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // tick until done; lat = edges taken, bcnt = samples with busy high
  task automatic wait_done(output int l, inout int b);
    l = 0;
    while (l < 40) begin
      tick();
      l++;
      if (busy) b++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 32'(l), 32'd16);
  endtask

  task automatic launch(input logic [15:0] m, input logic n);
    mag   = m;
    neg   = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [19:0] eb,
                           input logic [4:0] ee, input logic es);
    chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
    chk({tag, "_en"}, 32'(en), 32'(ee));
    chk({tag, "_sign"}, 32'(neg_o), 32'(es));
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) c++;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mag   = '0;
    neg   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    check_res("rst", 20'h0, 5'b00001, 1'b0);

    // 12345; inputs scrambled right after the start edge
    launch(16'd12345, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    mag = 16'hBEEF;
    neg = 1'b1;
    bcnt = 1;
    wait_done(lat, bcnt);
    chk("t1_lat", 32'(lat), 32'd16);
    check_res("t1", 20'h12345, 5'b11111, 1'b0);
    tick();
    chk("t1_pulse", 32'(done), 32'd0);
    check_res("t1_hold", 20'h12345, 5'b11111, 1'b0);

    launch(16'hFFFF, 1'b0);
    bcnt = 1;
    wait_done(lat, bcnt);
    chk("t2_busy_len", 32'(bcnt), 32'd16);
    check_res("t2", 20'h65535, 5'b11111, 1'b0);

    launch(16'd7, 1'b1);
    bcnt = 1;
    wait_done(lat, bcnt);
    check_res("t3a", 20'h00007, 5'b00001, 1'b1);

    launch(16'd0, 1'b1);
    bcnt = 1;
    wait_done(lat, bcnt);
    check_res("t3b", 20'h00000, 5'b00001, 1'b0);

    // second start during busy must be ignored
    launch(16'd100, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    launch(16'd9, 1'b0);
    bcnt = 0;
    wait_done(lat, bcnt);
    chk("t4_lat", 32'(lat), 32'd11);
    check_res("t4", 20'h00100, 5'b00111, 1'b0);
    count_done(20, dcnt);
    chk("t4_single", 32'(dcnt), 32'd0);

    // reset mid-conversion
    launch(16'd500, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    check_res("t5_rst", 20'h0, 5'b00001, 1'b0);
    count_done(20, dcnt);
    chk("t5_nodone", 32'(dcnt), 32'd0);
    launch(16'd42, 1'b0);
    bcnt = 1;
    wait_done(lat, bcnt);
    chk("t5_lat", 32'(lat), 32'd16);
    check_res("t5", 20'h00042, 5'b00011, 1'b0);

    // Start held high: a result every 17 cycles
    mag   = 16'd999;
    neg   = 1'b0;
    start = 1'b1;
    tick();
    bcnt = 1;
    wait_done(lat, bcnt);
    chk("t6_lat0", 32'(lat), 32'd16);
    check_res("t6_0", 20'h00999, 5'b00111, 1'b0);
    for (int r = 1; r < 4; r++) begin
      wait_done(lat, bcnt);
      chk("t6_period", 32'(lat), 32'd17);
      check_res("t6_n", 20'h00999, 5'b00111, 1'b0);
    end
    start = 1'b0;
    count_done(20, dcnt);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
